case_stream_xform: RTL



---
 rtl/case_xform_pkg.sv | 35 +++
 rtl/case_xform_fifo2.sv | 69 ++++++
 rtl/case_stream_xform.sv | 99 +++++++++
 3 files changed

// File: rtl/case_xform_pkg.sv
// Shared types and helpers for the multi-channel case-transform stream.
// Holds the mode encoding, command bytes and the pure byte transform.
package case_xform_pkg;

  typedef enum logic [1:0] {
    MODE_N = 2'd0,
    MODE_L = 2'd1,
    MODE_U = 2'd2,
    MODE_C = 2'd3
  } mode_t;

  localparam logic [7:0] CMD_L       = 8'h4C;
  localparam logic [7:0] CMD_U       = 8'h55;
  localparam logic [7:0] CMD_N       = 8'h4E;
  localparam logic [7:0] CMD_C       = 8'h43;
  localparam logic [7:0] ESC_DEFAULT = 8'h1B;

  function automatic logic [7:0] xform(input mode_t m, input logic [7:0] b);
    logic is_up;
    logic is_lo;
    logic [7:0] r;
    is_up = (b >= 8'h41) && (b <= 8'h5A);
    is_lo = (b >= 8'h61) && (b <= 8'h7A);
    r = b;
    if (is_up && (m == MODE_L || m == MODE_C)) r = b + 8'h20;
    if (is_lo && (m == MODE_U || m == MODE_C)) r = b - 8'h20;
    return r;
  endfunction

  // One-hot layout is {C,U,L,N}, so the mode value is the bit position.
  function automatic logic [3:0] mode_onehot(input mode_t m);
    return 4'b0001 << m;
  endfunction

endpackage

// File: rtl/case_xform_fifo2.sv
// Two-entry in-order {chan,data} buffer with valid/ready on both sides.
// push_ready depends only on the registered count, never on pop_ready.
module case_xform_fifo2 #(
  parameter int CW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [CW-1:0] push_chan,
  input  logic [7:0]    push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [CW-1:0] pop_chan,
  output logic [7:0]    pop_data
);
  logic [1:0]    count_q, count_d;
  logic          wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] chan_q [2];
  logic [CW-1:0] chan_d [2];
  logic [7:0]    data_q [2];
  logic [7:0]    data_d [2];
  logic          push, pop;

  assign push_ready = (count_q != 2'd2);
  assign pop_valid  = (count_q != 2'd0);
  assign pop_chan   = chan_q[rd_q];
  assign pop_data   = data_q[rd_q];

  always_comb begin
    push    = push_valid & push_ready;
    pop     = pop_valid & pop_ready;
    chan_d  = chan_q;
    data_d  = data_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) begin
      chan_d[wr_q] = push_chan;
      data_d[wr_q] = push_data;
      wr_d         = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= 2'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // Payload storage needs no reset: it is only observed behind pop_valid.
  always_ff @(posedge clock) begin
    chan_q <= chan_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/case_stream_xform.sv
// Multi-channel escape-driven case transform with per-channel mode/escape
// state; command bytes are consumed, data bytes go out through a 2-entry FIFO.
module case_stream_xform
  import case_xform_pkg::*;
#(
  parameter int         CHANNELS = 4,
  parameter int         CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter logic [7:0] ESC      = ESC_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_data,
  input  logic [CW-1:0]           in_chan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_data,
  output logic [CW-1:0]           out_chan,
  output logic [4*CHANNELS-1:0]   mode,
  output logic                    err,
  output logic [CW-1:0]           err_chan
);
  mode_t         mode_q [CHANNELS];
  mode_t         mode_d [CHANNELS];
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic          err_q, err_d;
  logic [CW-1:0] err_chan_q, err_chan_d;
  logic          accept, chan_ok, push;
  logic [7:0]    push_data;

  assign err      = err_q;
  assign err_chan = err_chan_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_mode
    assign mode[4*k +: 4] = mode_onehot(mode_q[k]);
  end

  always_comb begin
    mode_d     = mode_q;
    pend_d     = pend_q;
    err_d      = 1'b0;
    err_chan_d = err_chan_q;
    push       = 1'b0;
    push_data  = in_data;
    accept     = in_valid & in_ready;
    chan_ok    = ({1'b0, in_chan} < (CW+1)'(CHANNELS));
    if (accept) begin
      if (!chan_ok) begin
        err_d      = 1'b1;
        err_chan_d = in_chan;
      end else if (pend_q[in_chan]) begin
        pend_d[in_chan] = 1'b0;
        if      (in_data == CMD_L) mode_d[in_chan] = MODE_L;
        else if (in_data == CMD_U) mode_d[in_chan] = MODE_U;
        else if (in_data == CMD_N) mode_d[in_chan] = MODE_N;
        else if (in_data == CMD_C) mode_d[in_chan] = MODE_C;
        else if (in_data == ESC)   push = 1'b1;  // escaped ESC goes out untransformed
        else begin
          err_d      = 1'b1;
          err_chan_d = in_chan;
        end
      end else if (in_data == ESC) begin
        pend_d[in_chan] = 1'b1;
      end else begin
        push      = 1'b1;
        push_data = xform(mode_q[in_chan], in_data);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++) mode_q[k] <= MODE_N;
      pend_q     <= '0;
      err_q      <= 1'b0;
      err_chan_q <= '0;
    end else begin
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      err_chan_q <= err_chan_d;
    end
  end

  case_xform_fifo2 #(.CW(CW)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_valid (push),
    .push_ready (in_ready),
    .push_chan  (in_chan),
    .push_data  (push_data),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_chan   (out_chan),
    .pop_data   (out_data)
  );

endmodule
